// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the MEM-stage access unit and data memory.
// The access unit is the master (issues req/addr/wdata); memory is the slave.
interface mem_access_unit_if;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_addr,
        output data_wstrb,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_addr,
        input  data_wstrb,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine.
// Formats stores, checks alignment, runs the req/addr_ok/data_ok handshake,
// extracts/extends load data and stalls the pipeline while a transfer is open.
// A transfer that sees no data_ok within MAX_WAIT cycles of leaving IDLE
// ends as a bus error.
module mem_access_unit #(
    parameter logic [7:0] MAX_WAIT = 8'd255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    MEMmemread,
    input  logic                    MEMmemwrite,
    input  logic                    MEMfull,
    input  logic                    MEMhalf,
    input  logic                    MEMbyte,
    input  logic                    MEMsignload,
    input  logic [8:0]              MEMexcept,
    input  logic [31:0]             MEMaluresult,
    input  logic [31:0]             MEMdata,
    mem_access_unit_if.master       bus,
    output logic                    mem_stall,
    output logic [31:0]             mem_rdata,
    output logic                    mem_rdata_valid,
    output logic [1:0]              mem_exc,
    output logic [31:0]             mem_badvaddr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Last counter value at which a transfer may still complete normally.
    localparam logic [7:0] WAIT_LAST = MAX_WAIT - 8'd1;

    // Little-endian byte enables for a store of the given size at the given offset.
    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] s;
        case (size)
            SZ_BYTE: s = 4'b0001 << off;
            SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Store data replicated across all lanes so the strobes pick the right bytes.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Select the addressed lane of the read word and sign/zero-extend it.
    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sign,
                                                input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (size)
            SZ_BYTE: r = {{24{sign & b[7]}}, b};
            SZ_HALF: r = {{16{sign & h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    logic [1:0]  state_r;
    logic [31:0] addr_r;
    logic        wr_r;
    logic [1:0]  size_r;
    logic        sign_r;
    logic [3:0]  wstrb_r;
    logic [31:0] wdata_r;
    logic [7:0]  wait_cnt_r;
    logic        kill_r;
    logic        rdata_valid_r;
    logic        bus_exc_r;
    logic [31:0] mem_rdata_r;

    logic        misalign_s;
    logic        access_s;
    logic        clean_s;
    logic        go_s;
    logic        align_exc_s;
    logic        wr_s;
    logic [1:0]  size_s;
    logic        kill_s;
    logic        data_done_s;

    // Decode the MEM-stage instruction: size, alignment and whether to start.
    always_comb begin
        misalign_s = (MEMfull & (MEMaluresult[1:0] != 2'b00)) | (MEMhalf & MEMaluresult[0]);
        access_s   = MEMmemread | MEMmemwrite;
        clean_s    = (MEMexcept == 9'd0);
        wr_s       = MEMmemwrite & ~MEMmemread;
        if (MEMfull) begin
            size_s = SZ_WORD;
        end else if (MEMhalf) begin
            size_s = SZ_HALF;
        end else begin
            size_s = SZ_BYTE;
        end
        if (state_r == ST_IDLE) begin
            go_s        = access_s & ~misalign_s & clean_s & ~flush & reset;
            align_exc_s = access_s & misalign_s & clean_s;
        end else begin
            go_s        = 1'b0;
            align_exc_s = 1'b0;
        end
    end

    // Handshake progress: a flush in ADDR/DATA kills the result of the open transfer.
    always_comb begin
        kill_s = kill_r | flush;
        if (state_r == ST_ADDR) begin
            data_done_s = bus.data_addr_ok & bus.data_data_ok;
        end else if (state_r == ST_DATA) begin
            data_done_s = bus.data_data_ok;
        end else begin
            data_done_s = 1'b0;
        end
    end

    // Transfer sequencing, request latching, timeout counting and result capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            addr_r        <= 32'd0;
            wr_r          <= 1'b0;
            size_r        <= SZ_BYTE;
            sign_r        <= 1'b0;
            wstrb_r       <= 4'b0000;
            wdata_r       <= 32'd0;
            wait_cnt_r    <= 8'd0;
            kill_r        <= 1'b0;
            rdata_valid_r <= 1'b0;
            bus_exc_r     <= 1'b0;
            mem_rdata_r   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rdata_valid_r <= 1'b0;
                    bus_exc_r     <= 1'b0;
                    kill_r        <= 1'b0;
                    wait_cnt_r    <= 8'd0;
                    if (go_s) begin
                        state_r <= ST_ADDR;
                        addr_r  <= MEMaluresult;
                        wr_r    <= wr_s;
                        size_r  <= size_s;
                        sign_r  <= MEMsignload;
                        wstrb_r <= wr_s ? store_strb(size_s, MEMaluresult[1:0]) : 4'b0000;
                        wdata_r <= store_data(size_s, MEMdata);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    wait_cnt_r <= wait_cnt_r + 8'd1;
                    kill_r     <= kill_s;
                    if (data_done_s) begin
                        // data_ok takes priority over a coinciding timeout
                        state_r       <= ST_DONE;
                        rdata_valid_r <= ~wr_r & ~kill_s;
                        if (!wr_r) begin
                            mem_rdata_r <= load_extend(size_r, sign_r, addr_r[1:0], bus.data_rdata);
                        end else begin
                            mem_rdata_r <= mem_rdata_r;
                        end
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r   <= ST_DONE;
                        bus_exc_r <= ~kill_s;
                    end else if ((state_r == ST_ADDR) && bus.data_addr_ok) begin
                        state_r <= ST_DATA;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_DONE: begin
                    // Always return to IDLE so the same instruction is never reissued
                    state_r       <= ST_IDLE;
                    rdata_valid_r <= 1'b0;
                    bus_exc_r     <= 1'b0;
                    kill_r        <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    rdata_valid_r <= 1'b0;
                    bus_exc_r     <= 1'b0;
                    kill_r        <= 1'b0;
                end
            endcase
        end
    end

    // Exception reporting: alignment faults are immediate, bus errors show in DONE.
    always_comb begin
        if (align_exc_s) begin
            mem_exc      = MEMmemread ? 2'b01 : 2'b10;
            mem_badvaddr = MEMaluresult;
        end else if (bus_exc_r) begin
            mem_exc      = 2'b11;
            mem_badvaddr = addr_r;
        end else begin
            mem_exc      = 2'b00;
            mem_badvaddr = 32'd0;
        end
    end

    // Bus is driven only from latched request state.
    assign bus.data_req   = (state_r == ST_ADDR);
    assign bus.data_wr    = wr_r;
    assign bus.data_addr  = {addr_r[31:2], 2'b00};
    assign bus.data_wstrb = wstrb_r;
    assign bus.data_wdata = wdata_r;

    assign mem_stall       = go_s | (state_r == ST_ADDR) | (state_r == ST_DATA);
    assign mem_rdata       = mem_rdata_r;
    assign mem_rdata_valid = rdata_valid_r;

endmodule
